// File: rtl/acia_uart_if.sv
// CPU-side register bus of the ACIA: decoder strobes, register select,
// write/read data and the interrupt request.
interface acia_uart_if;
    logic       rs;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_n;

    modport master (
        output rs,
        output rd_n,
        output wr_n,
        output wdata,
        input  rdata,
        input  irq_n
    );

    modport slave (
        input  rs,
        input  rd_n,
        input  wr_n,
        input  wdata,
        output rdata,
        output irq_n
    );
endinterface

// File: rtl/acia_uart.sv
// 6850-style byte UART: 8N1 transmitter and receiver, one-byte holding register
// each way, overrun/framing flags and a registered active-low interrupt.
module acia_uart #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_eclk,
    input  logic       i_reset,
    acia_uart_if.slave bus,
    input  logic       i_rxd,
    output logic       o_txd
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Bus strobe edge detection
    logic rd_q, wr_q;
    logic wr_fall, rd_fall, data_wr, ctrl_wr, data_rd, mreset, soft_rst;

    always_ff @(posedge i_eclk) begin
        if (i_reset) begin
            rd_q <= 1'b1;
            wr_q <= 1'b1;
        end else begin
            rd_q <= bus.rd_n;
            wr_q <= bus.wr_n;
        end
    end

    // A write starting in the same cycle as a read masks the read.
    assign wr_fall  = wr_q & ~bus.wr_n;
    assign rd_fall  = rd_q & ~bus.rd_n & ~wr_fall;
    assign data_wr  = wr_fall & bus.rs;
    assign ctrl_wr  = wr_fall & ~bus.rs;
    assign data_rd  = rd_fall & bus.rs;
    assign mreset   = ctrl_wr & (bus.wdata[1:0] == 2'b11);
    assign soft_rst = i_reset | mreset;

    logic rie_q, tie_q;

    always_ff @(posedge i_eclk) begin
        if (i_reset) begin
            rie_q <= 1'b0;
            tie_q <= 1'b0;
        end else if (ctrl_wr) begin
            rie_q <= bus.wdata[7];
            tie_q <= bus.wdata[6];
        end
    end

    // Transmitter
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_load;
    logic [7:0]    tdr_q;
    logic          tdre_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (!tdre_q) begin
                    tx_load    = 1'b1;
                    tx_shift_d = tdr_q;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end
                end
            end
            TxStop: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // Line follows the current state, so o_txd lags the state by one cycle.
    always_comb begin
        txd_d = 1'b1;
        if (tx_state_q == TxStart) begin
            txd_d = 1'b0;
        end else if (tx_state_q == TxData) begin
            txd_d = tx_shift_q[0];
        end
    end

    always_ff @(posedge i_eclk) begin
        if (soft_rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    always_ff @(posedge i_eclk) begin
        if (soft_rst) begin
            tdr_q  <= 8'h00;
            tdre_q <= 1'b1;
        end else if (data_wr) begin
            tdr_q  <= bus.wdata;
            tdre_q <= 1'b0;
        end else if (tx_load) begin
            tdre_q <= 1'b1;
        end
    end

    // Receiver
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_done;
    logic [7:0]    rdr_q;
    logic          rdrf_q, ovrn_q, fe_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_done    = 1'b1;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge i_eclk) begin
        if (soft_rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_s1_q    <= i_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // A data read landing on the completion edge frees RDR for the new byte.
    always_ff @(posedge i_eclk) begin
        if (soft_rst) begin
            rdr_q  <= 8'h00;
            rdrf_q <= 1'b0;
            ovrn_q <= 1'b0;
            fe_q   <= 1'b0;
        end else if (rx_done) begin
            fe_q <= ~rx_s2_q;
            if (!rdrf_q || data_rd) begin
                rdr_q  <= rx_shift_q;
                rdrf_q <= 1'b1;
                ovrn_q <= ovrn_q & ~data_rd;
            end else begin
                ovrn_q <= 1'b1;
            end
        end else if (data_rd) begin
            rdrf_q <= 1'b0;
            ovrn_q <= 1'b0;
            fe_q   <= 1'b0;
        end
    end

    logic irq_n_q;

    always_ff @(posedge i_eclk) begin
        if (soft_rst) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= ~((rie_q & (rdrf_q | ovrn_q)) | (tie_q & tdre_q));
        end
    end

    logic [7:0] status;
    assign status    = {~irq_n_q, 1'b0, ovrn_q, fe_q, 2'b00, tdre_q, rdrf_q};
    assign bus.rdata = bus.rs ? rdr_q : status;
    assign bus.irq_n = irq_n_q;
    assign o_txd     = txd_q;
endmodule
